// File: rtl/jtframe_adc_pkg.sv
// Shared types and constants for the ADC conditioning blocks.
package jtframe_adc_pkg;

  localparam int ADC_W = 12;
  localparam int OUT_W = 8;
  localparam int DIV_W = 20;

  localparam logic [OUT_W-1:0] NEUTRAL = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    RANGE,
    DIV,
    OUT
  } state_t;

endpackage

// File: rtl/jtframe_adc_scale_if.sv
// Sample-in / scaled-value-out bundle between jtframe_2308 consumers and jtframe_adc_scale.
interface jtframe_adc_scale_if;
  import jtframe_adc_pkg::*;

  logic             cen;
  logic [ADC_W-1:0] adc_read;
  logic [OUT_W-1:0] dout;
  logic             dout_ok;
  logic             busy;
  logic [ADC_W-1:0] cal_min;
  logic [ADC_W-1:0] cal_max;

  modport master (
    output cen, adc_read,
    input  dout, dout_ok, busy, cal_min, cal_max
  );

  modport slave (
    input  cen, adc_read,
    output dout, dout_ok, busy, cal_min, cal_max
  );

endinterface

// File: rtl/jtframe_udiv.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// The first bit is resolved on the start cycle, so done pulses NUM_W cycles after start.
module jtframe_udiv #(
  parameter int NUM_W = 20,
  parameter int DEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quot
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem, rem_nx, den_r, d_in, r_in;
  logic [NUM_W-1:0] nq, nq_nx, n_in;
  logic [DEN_W:0]   trial;
  logic [CNT_W-1:0] cnt;
  logic             q_bit;

  // nq starts as the numerator and fills with quotient bits from the bottom.
  always_comb begin
    r_in  = start ? '0  : rem;
    n_in  = start ? num : nq;
    d_in  = start ? den : den_r;
    trial = {r_in, n_in[NUM_W-1]};
    if (trial >= {1'b0, d_in}) begin
      rem_nx = DEN_W'(trial - {1'b0, d_in});
      q_bit  = 1'b1;
    end else begin
      rem_nx = trial[DEN_W-1:0];
      q_bit  = 1'b0;
    end
    nq_nx = {n_in[NUM_W-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem   <= '0;
      nq    <= '0;
      den_r <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem   <= rem_nx;
        nq    <= nq_nx;
        den_r <= den;
        cnt   <= CNT_W'(1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem <= rem_nx;
        nq  <= nq_nx;
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(NUM_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quot = nq;

endmodule

// File: rtl/jtframe_adc_scale.sv
// Averages LTC2308 readings and rescales them to an 8-bit control value.
// Define JTFRAME_ADC_SCALE_CAL_EN for min/max auto-calibration; otherwise FIX_MIN/FIX_MAX bound the range.
module jtframe_adc_scale
  import jtframe_adc_pkg::*;
#(
  parameter int               AVG_LOG2 = 2,
  parameter logic [ADC_W-1:0] MINSPAN  = 12'd64,
  parameter logic [ADC_W-1:0] FIX_MIN  = 12'd0,
  parameter logic [ADC_W-1:0] FIX_MAX  = 12'hFFF
) (
  input logic               clk,
  input logic               rst_n,
  jtframe_adc_scale_if.slave bus
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int WP_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W = ADC_W + AVG_LOG2;

  state_t            state, state_nx;
  logic [ADC_W-1:0]  smp, avg;
  logic [ACC_W-1:0]  acc, acc_nx;
  logic [ADC_W-1:0]  ring [DEPTH];
  logic [WP_W-1:0]   wp, wp_nx;
  logic [OUT_W-1:0]  dout_r;

  logic [ADC_W-1:0]  min_use, max_use, span, off;
  logic              range_ok;
  logic [DIV_W-1:0]  num, quot;
  logic              div_start, div_busy, div_done;

  assign acc_nx = acc + ACC_W'(smp) - ACC_W'(ring[wp]);
  assign wp_nx  = (wp == WP_W'(DEPTH - 1)) ? '0 : wp + 1'b1;

`ifdef JTFRAME_ADC_SCALE_CAL_EN
  logic [ADC_W-1:0] cal_min_r, cal_max_r;

  always_comb begin
    min_use = (avg < cal_min_r) ? avg : cal_min_r;
    max_use = (avg > cal_max_r) ? avg : cal_max_r;
    off     = avg - min_use;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cal_min_r <= 12'hFFF;
      cal_max_r <= 12'h000;
    end else if (state == RANGE) begin
      cal_min_r <= min_use;
      cal_max_r <= max_use;
    end
  end

  assign bus.cal_min = cal_min_r;
  assign bus.cal_max = cal_max_r;
`else
  always_comb begin
    min_use = FIX_MIN;
    max_use = FIX_MAX;
    if (avg <= FIX_MIN)      off = '0;
    else if (avg >= FIX_MAX) off = FIX_MAX - FIX_MIN;
    else                     off = avg - FIX_MIN;
  end

  assign bus.cal_min = FIX_MIN;
  assign bus.cal_max = FIX_MAX;
`endif

  // Below the minimum span the reading is noise, so the neutral value is reported instead.
  assign span     = max_use - min_use;
  assign range_ok = (max_use > min_use) && (span >= MINSPAN);
  assign num      = {off, 8'h00} - DIV_W'(off);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    unique case (state)
      IDLE:  if (bus.cen) state_nx = ACC;
      ACC:   state_nx = RANGE;
      RANGE: begin
        if (range_ok) begin
          div_start = 1'b1;
          state_nx  = DIV;
        end else begin
          state_nx  = OUT;
        end
      end
      DIV:   if (div_done && !div_busy) state_nx = OUT;
      OUT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp    <= '0;
      avg    <= '0;
      acc    <= '0;
      wp     <= '0;
      dout_r <= NEUTRAL;
      // NOTE: the ring buffer must be cleared by reset so acc stays equal to the sum of
      // its entries; this keeps it in flops rather than a RAM macro, which is fine at this size.
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.cen) smp <= bus.adc_read;
        ACC: begin
          acc      <= acc_nx;
          ring[wp] <= smp;
          wp       <= wp_nx;
          avg      <= ADC_W'(acc_nx >> AVG_LOG2);
        end
        RANGE: if (!range_ok) dout_r <= NEUTRAL;
        DIV: if (div_done && !div_busy)
          dout_r <= (|quot[DIV_W-1:OUT_W]) ? 8'hFF : quot[OUT_W-1:0];
        default: ;
      endcase
    end
  end

  jtframe_udiv #(
    .NUM_W (DIV_W),
    .DEN_W (ADC_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (num),
    .den   (span),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (quot)
  );

  assign bus.dout    = dout_r;
  assign bus.dout_ok = (state == OUT);
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_jtframe_adc_scale.sv
// Directed bench for jtframe_adc_scale: a default instance, a clamp instance and a narrow-span instance.
module tb_jtframe_adc_scale;
  import jtframe_adc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtframe_adc_scale_if if_a ();
  jtframe_adc_scale_if if_b ();
  jtframe_adc_scale_if if_c ();

  jtframe_adc_scale u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  jtframe_adc_scale #(
    .AVG_LOG2 (0),
    .MINSPAN  (12'd64),
    .FIX_MIN  (12'd1000),
    .FIX_MAX  (12'd2020)
  ) u_clamp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  jtframe_adc_scale #(
    .AVG_LOG2 (0),
    .MINSPAN  (12'd64),
    .FIX_MIN  (12'd1000),
    .FIX_MAX  (12'd1040)
  ) u_narrow (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_c)
  );

  int vectors     = 0;
  int miscompares = 0;

`ifdef JTFRAME_ADC_SCALE_CAL_EN
  localparam int N_MAIN = 12;
  logic [11:0] main_val [N_MAIN] = '{1000, 1000, 1000, 1000, 3000, 3000, 3000, 3000, 1000, 1000, 1000, 1000};
  logic [7:0]  main_exp [N_MAIN] = '{8'h80, 255, 255, 255, 255, 255, 255, 255, 208, 162, 115, 69};
  int          main_lat [N_MAIN] = '{3, 23, 23, 23, 23, 23, 23, 23, 23, 23, 23, 23};
  logic [7:0]  clamp_exp [3] = '{8'h80, 255, 103};
  int          clamp_lat [3] = '{3, 23, 23};
  logic [11:0] rst_min_a = 12'hFFF, rst_max_a = 12'h000;
  logic [11:0] rst_min_b = 12'hFFF, rst_max_b = 12'h000;
  logic [7:0]  drop_exp1 = 8'd46, drop_exp2 = 8'd23;
  logic [7:0]  post_exp = 8'h80;
  int          post_lat = 3;
`else
  localparam int N_MAIN = 8;
  logic [11:0] main_val [N_MAIN] = '{2048, 2048, 2048, 2048, 4095, 4095, 4095, 4095};
  logic [7:0]  main_exp [N_MAIN] = '{31, 63, 95, 127, 159, 191, 223, 255};
  int          main_lat [N_MAIN] = '{23, 23, 23, 23, 23, 23, 23, 23};
  logic [7:0]  clamp_exp [3] = '{0, 255, 127};
  int          clamp_lat [3] = '{23, 23, 23};
  logic [11:0] rst_min_a = 12'd0,    rst_max_a = 12'hFFF;
  logic [11:0] rst_min_b = 12'd1000, rst_max_b = 12'd2020;
  logic [7:0]  drop_exp1 = 8'd191, drop_exp2 = 8'd127;
  logic [7:0]  post_exp = 8'd31;
  int          post_lat = 23;
`endif
  logic [11:0] clamp_val [3] = '{500, 3000, 1510};

  task automatic drive(input int which, input logic c, input logic [11:0] v);
    case (which)
      0:       begin if_a.cen = c; if_a.adc_read = v; end
      1:       begin if_b.cen = c; if_b.adc_read = v; end
      default: begin if_c.cen = c; if_c.adc_read = v; end
    endcase
  endtask

  function automatic logic ok_of(input int which);
    case (which)
      0:       return if_a.dout_ok;
      1:       return if_b.dout_ok;
      default: return if_c.dout_ok;
    endcase
  endfunction

  function automatic logic [7:0] dout_of(input int which);
    case (which)
      0:       return if_a.dout;
      1:       return if_b.dout;
      default: return if_c.dout;
    endcase
  endfunction

  // Strobe one sample and report the cycle (accepted cen = cycle 0) of the first dout_ok.
  task automatic send(input int which, input logic [11:0] val, output int lat, output logic [7:0] d);
    lat = -1;
    d   = 'x;
    @(negedge clk);
    drive(which, 1'b1, val);
    @(negedge clk);
    drive(which, 1'b0, 12'd0);
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (ok_of(which)) begin
        lat = n;
        d   = dout_of(which);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 12'd0);
    drive(1, 1'b0, 12'd0);
    drive(2, 1'b0, 12'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (if_a.dout !== 8'h80) begin miscompares++; $display("FAIL reset dout: got %h expected 80", if_a.dout); end
    vectors++;
    if (if_a.dout_ok !== 1'b0) begin miscompares++; $display("FAIL reset dout_ok: got %b expected 0", if_a.dout_ok); end
    vectors++;
    if (if_a.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", if_a.busy); end
    vectors++;
    if (if_a.cal_min !== rst_min_a) begin miscompares++; $display("FAIL reset cal_min: got %0d expected %0d", if_a.cal_min, rst_min_a); end
    vectors++;
    if (if_a.cal_max !== rst_max_a) begin miscompares++; $display("FAIL reset cal_max: got %0d expected %0d", if_a.cal_max, rst_max_a); end
    vectors++;
    if (if_b.cal_min !== rst_min_b || if_b.cal_max !== rst_max_b) begin
      miscompares++;
      $display("FAIL reset clamp range: got %0d..%0d expected %0d..%0d", if_b.cal_min, if_b.cal_max, rst_min_b, rst_max_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_main();
    int lat;
    logic [7:0] d;
    for (int i = 0; i < N_MAIN; i++) begin
      send(0, main_val[i], lat, d);
      vectors++;
      if (lat !== main_lat[i]) begin miscompares++; $display("FAIL main[%0d] latency: got %0d expected %0d", i, lat, main_lat[i]); end
      vectors++;
      if (d !== main_exp[i]) begin miscompares++; $display("FAIL main[%0d] dout: got %0d expected %0d", i, d, main_exp[i]); end
`ifdef JTFRAME_ADC_SCALE_CAL_EN
      if (i == 7) begin
        vectors++;
        if (if_a.cal_min !== 12'd250 || if_a.cal_max !== 12'd3000) begin
          miscompares++;
          $display("FAIL main cal range: got %0d..%0d expected 250..3000", if_a.cal_min, if_a.cal_max);
        end
      end
`endif
    end
  endtask

  task automatic test_clamp();
    int lat;
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      send(1, clamp_val[i], lat, d);
      vectors++;
      if (lat !== clamp_lat[i] || d !== clamp_exp[i]) begin
        miscompares++;
        $display("FAIL clamp[%0d]: got %0d at cycle %0d expected %0d at cycle %0d", i, d, lat, clamp_exp[i], clamp_lat[i]);
      end
    end
  endtask

  task automatic test_span_small();
    int lat;
    logic [7:0] d;
    for (int i = 0; i < 2; i++) begin
      send(2, 12'd500, lat, d);
      vectors++;
      if (lat !== 3 || d !== 8'h80) begin
        miscompares++;
        $display("FAIL span_small[%0d]: got %h at cycle %0d expected 80 at cycle 3", i, d, lat);
      end
    end
  endtask

  task automatic test_dropped();
    int lat, first, oks;
    logic [7:0] d, first_d;
    first   = -1;
    first_d = 'x;
    oks     = 0;
    @(negedge clk);
    drive(0, 1'b1, 12'd0);
    @(negedge clk);
    drive(0, 1'b0, 12'd0);
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 10) drive(0, 1'b1, 12'd2048);
      if (n == 11) drive(0, 1'b0, 12'd0);
      if (if_a.dout_ok) begin
        oks++;
        if (first < 0) begin first = n; first_d = if_a.dout; end
      end
    end
    vectors++;
    if (oks !== 1) begin miscompares++; $display("FAIL dropped pulses: got %0d expected 1", oks); end
    vectors++;
    if (first !== 23 || first_d !== drop_exp1) begin
      miscompares++;
      $display("FAIL dropped first: got %0d at cycle %0d expected %0d at cycle 23", first_d, first, drop_exp1);
    end
    send(0, 12'd0, lat, d);
    vectors++;
    if (lat !== 23 || d !== drop_exp2) begin
      miscompares++;
      $display("FAIL dropped follow-up: got %0d at cycle %0d expected %0d at cycle 23", d, lat, drop_exp2);
    end
  endtask

  task automatic test_reset_mid();
    int lat, oks;
    logic [7:0] d;
    oks = 0;
    @(negedge clk);
    drive(0, 1'b1, 12'd4095);
    @(negedge clk);
    drive(0, 1'b0, 12'd0);
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (if_a.dout_ok) oks++;
      if (n == 14) rst_n = 1'b0;
      if (n == 15) begin
        rst_n = 1'b1;
        vectors++;
        if (if_a.busy !== 1'b0 || if_a.dout !== 8'h80) begin
          miscompares++;
          $display("FAIL reset_mid state: got busy=%b dout=%h expected busy=0 dout=80", if_a.busy, if_a.dout);
        end
      end
    end
    vectors++;
    if (oks !== 0) begin miscompares++; $display("FAIL reset_mid pulses: got %0d expected 0", oks); end
    send(0, 12'd2048, lat, d);
    vectors++;
    if (lat !== post_lat || d !== post_exp) begin
      miscompares++;
      $display("FAIL reset_mid restart: got %0d at cycle %0d expected %0d at cycle %0d", d, lat, post_exp, post_lat);
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_clamp();
    test_span_small();
    test_dropped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
